// File: rtl/css_mcu0_el2_ifu_rvc_packer.sv
// RV32 -> RVC compressor feeding a 3-halfword packer that emits 32-bit little-endian words.
// No output register: out_data = {hw1,hw0} once two halfwords are buffered; in_ready follows out_ready when full.
module css_mcu0_el2_ifu_rvc_packer (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] comp_cnt
);

  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        imm_fits6;
  logic        lw_ok;
  logic        sw_ok;
  logic        comp_vld;
  logic [15:0] comp_hw;

  logic [1:0]  count_q, count_d;
  logic [15:0] hw0_q, hw0_d;
  logic [15:0] hw1_q, hw1_d;
  logic [15:0] hw2_q, hw2_d;
  logic [15:0] comp_cnt_q, comp_cnt_d;
  logic        push;
  logic        pop;
  logic [1:0]  base;
  logic [15:0] nh0;
  logic [15:0] nh1;

  assign rd  = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // I-imm fits in 6 signed bits when imm[11:5] is a pure sign extension.
  assign imm_fits6 = (in_instr[31:25] == 7'h00) | (in_instr[31:25] == 7'h7f);
  assign lw_ok = (rd[4:3] == 2'b01) & (rs1[4:3] == 2'b01) &
                 (in_instr[31:27] == 5'd0) & (in_instr[21:20] == 2'd0);
  assign sw_ok = (rs2[4:3] == 2'b01) & (rs1[4:3] == 2'b01) &
                 (in_instr[31:27] == 5'd0) & (in_instr[8:7] == 2'd0);

  always_comb begin
    comp_vld = 1'b0;
    comp_hw  = 16'h0000;
    if (in_instr == 32'h0000_0013) begin
      comp_vld = 1'b1;
      comp_hw  = 16'h0001;
    end else if (opc == 7'h13 && f3 == 3'b000 && rd != 5'd0 && rs1 == 5'd0 && imm_fits6) begin
      comp_vld = 1'b1;
      comp_hw  = {3'b010, in_instr[25], rd, in_instr[24:20], 2'b01};
    end else if (opc == 7'h13 && f3 == 3'b000 && rd != 5'd0 && rs1 == rd &&
                 in_instr[31:20] != 12'd0 && imm_fits6) begin
      comp_vld = 1'b1;
      comp_hw  = {3'b000, in_instr[25], rd, in_instr[24:20], 2'b01};
    end else if (opc == 7'h33 && f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 &&
                 rs2 != 5'd0 && rs1 == 5'd0) begin
      comp_vld = 1'b1;
      comp_hw  = {4'b1000, rd, rs2, 2'b10};
    end else if (opc == 7'h33 && f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 &&
                 rs2 != 5'd0 && rs1 == rd) begin
      comp_vld = 1'b1;
      comp_hw  = {4'b1001, rd, rs2, 2'b10};
    end else if (opc == 7'h03 && f3 == 3'b010 && lw_ok) begin
      comp_vld = 1'b1;
      comp_hw  = {3'b010, in_instr[25:23], rs1[2:0], in_instr[22], in_instr[26], rd[2:0], 2'b00};
    end else if (opc == 7'h23 && f3 == 3'b010 && sw_ok) begin
      comp_vld = 1'b1;
      comp_hw  = {3'b110, in_instr[25], in_instr[11:10], rs1[2:0], in_instr[9], in_instr[26],
                  rs2[2:0], 2'b00};
    end
  end

  assign out_valid = count_q[1];
  assign out_data  = {hw1_q, hw0_q};
  assign in_ready  = ~count_q[1] | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign nh0       = comp_vld ? comp_hw : in_instr[15:0];
  assign nh1       = in_instr[31:16];
  assign comp_cnt  = comp_cnt_q;

  always_comb begin
    hw0_d   = hw0_q;
    hw1_d   = hw1_q;
    hw2_d   = hw2_q;
    base    = count_q;
    count_d = count_q;
    if (pop) begin
      hw0_d = hw2_q;
      hw1_d = 16'h0000;
      hw2_d = 16'h0000;
      base  = count_q - 2'd2;
    end
    count_d = base;
    // A push only happens with base<=1, so new halfwords never run past hw2.
    if (push) begin
      if (base == 2'd0) begin
        hw0_d = nh0;
        if (!comp_vld) hw1_d = nh1;
      end else begin
        hw1_d = nh0;
        if (!comp_vld) hw2_d = nh1;
      end
      count_d = comp_vld ? base + 2'd1 : base + 2'd2;
    end else if (flush && count_q == 2'd1) begin
      hw1_d   = 16'h0001;
      count_d = 2'd2;
    end
  end

  always_comb begin
    comp_cnt_d = comp_cnt_q;
    if (push && comp_vld && comp_cnt_q != 16'hffff) comp_cnt_d = comp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_q    <= 2'd0;
      hw0_q      <= 16'h0000;
      hw1_q      <= 16'h0000;
      hw2_q      <= 16'h0000;
      comp_cnt_q <= 16'h0000;
    end else begin
      count_q    <= count_d;
      hw0_q      <= hw0_d;
      hw1_q      <= hw1_d;
      hw2_q      <= hw2_d;
      comp_cnt_q <= comp_cnt_d;
    end
  end

endmodule
